// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared types and widths for the Sobel frame controller and its line buffer.
package sobel_frame_ctrl_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_SIZE = 9;
  localparam int unsigned CNT_W    = 12;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StStream,
    StDone
  } state_t;

endpackage

// File: rtl/sobel_frame_ctrl_line_buffer.sv
// Two-line pixel store (rows r-2 and r-1) with registered read.
module sobel_line_buffer
  import sobel_frame_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [PIX_W-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [PIX_W-1:0]  o_rd_top,
  output logic [PIX_W-1:0]  o_rd_mid
);

  logic [PIX_W-1:0] r_mem_top [DEPTH];
  logic [PIX_W-1:0] r_mem_mid [DEPTH];

  // The caller reads the write column one edge ahead, so o_rd_mid already holds
  // the row being retired into the top line when the write lands.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem_top[i_wr_addr] <= o_rd_mid;
      r_mem_mid[i_wr_addr] <= i_wr_data;
    end
    o_rd_top <= r_mem_top[i_rd_addr];
    o_rd_mid <= r_mem_mid[i_rd_addr];
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer and 3x3 window generator feeding a Sobel core.
// Optional statistics ports are built when SOBEL_CTRL_STATS_EN is defined.
module sobel_frame_ctrl
  import sobel_frame_ctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PIX_W-1:0]          pix_in,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [PIX_W*WIN_SIZE-1:0] pixel_window,
  output logic                      window_valid,
  output logic [CNT_W-1:0]          win_row,
  output logic [CNT_W-1:0]          win_col,
  output logic                      busy,
  output logic                      frame_done
`ifdef SOBEL_CTRL_STATS_EN
  ,
  output logic [15:0]               frames_done,
  output logic                      overrun
`endif
);

  localparam int unsigned ADDR_W = $clog2(IMG_WIDTH);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_HEIGHT - 1);

  state_t                      r_state;
  logic [CNT_W-1:0]            r_row;
  logic [CNT_W-1:0]            r_col;
  logic                        r_pix_ready;
  logic                        r_busy;
  logic                        r_frame_done;
  logic                        r_win_valid;
  logic [PIX_W*WIN_SIZE-1:0]   r_window;
  logic [CNT_W-1:0]            r_win_row;
  logic [CNT_W-1:0]            r_win_col;
  logic [2:0][PIX_W-1:0]       r_c1;
  logic [2:0][PIX_W-1:0]       r_c2;

  logic                        w_xfer;
  logic                        w_col_last;
  logic                        w_emit;
  logic [CNT_W-1:0]            w_col_nxt;
  logic [PIX_W-1:0]            w_top;
  logic [PIX_W-1:0]            w_mid;
  logic [2:0][PIX_W-1:0]       w_new;
  logic [PIX_W*WIN_SIZE-1:0]   w_win;

  assign w_xfer     = pix_valid & r_pix_ready;
  assign w_col_last = (r_col == LAST_COL);
  assign w_emit     = w_xfer && (r_row >= CNT_W'(2)) && (r_col >= CNT_W'(2));
  assign w_new      = {pix_in, w_mid, w_top};

  // Column the counter will hold next cycle; drives the line-buffer read so
  // the data for the current column is already registered when it transfers.
  always_comb begin
    w_col_nxt = r_col;
    if (reset) begin
      w_col_nxt = '0;
    end else if (r_state == StIdle && start) begin
      w_col_nxt = '0;
    end else if (w_xfer) begin
      w_col_nxt = w_col_last ? '0 : r_col + 1'b1;
    end
  end

  always_comb begin
    w_win = '0;
    for (int i = 0; i < 3; i++) begin
      w_win[(3*i)*PIX_W   +: PIX_W] = r_c2[i];
      w_win[(3*i+1)*PIX_W +: PIX_W] = r_c1[i];
      w_win[(3*i+2)*PIX_W +: PIX_W] = w_new[i];
    end
  end

  sobel_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_line_buffer (
    .clk       (clk),
    .i_wr_en   (w_xfer),
    .i_wr_addr (r_col[ADDR_W-1:0]),
    .i_wr_data (pix_in),
    .i_rd_addr (w_col_nxt[ADDR_W-1:0]),
    .o_rd_top  (w_top),
    .o_rd_mid  (w_mid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_row        <= '0;
      r_col        <= '0;
      r_pix_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_win_valid  <= 1'b0;
      r_window     <= '0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_c1         <= '0;
      r_c2         <= '0;
    end else begin
      r_col       <= w_col_nxt;
      r_win_valid <= w_emit;
      if (w_xfer) begin
        r_c2 <= (r_col == '0) ? '0 : r_c1;
        r_c1 <= w_new;
      end
      if (w_emit) begin
        r_window  <= w_win;
        r_win_row <= r_row - 1'b1;
        r_win_col <= r_col - 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state     <= StPrime;
            r_row       <= '0;
            r_pix_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        StPrime: begin
          if (w_xfer && w_col_last) begin
            r_row <= r_row + 1'b1;
            if (r_row == CNT_W'(1)) r_state <= StStream;
          end
        end
        StStream: begin
          if (w_xfer && w_col_last) begin
            if (r_row == LAST_ROW) begin
              r_state      <= StDone;
              r_row        <= '0;
              r_pix_ready  <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        StDone: begin
          r_state      <= StIdle;
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign pix_ready    = r_pix_ready;
  assign pixel_window = r_window;
  assign window_valid = r_win_valid;
  assign win_row      = r_win_row;
  assign win_col      = r_win_col;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;

`ifdef SOBEL_CTRL_STATS_EN
  logic [15:0] r_frames_done;
  logic        r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frames_done <= '0;
      r_overrun     <= 1'b0;
    end else begin
      if (r_state == StDone) r_frames_done <= r_frames_done + 1'b1;
      if (pix_valid && (r_state == StIdle || r_state == StDone)) r_overrun <= 1'b1;
    end
  end

  assign frames_done = r_frames_done;
  assign overrun     = r_overrun;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl: 8x6 ramp frames plus a 3x3 instance.
// Checks the statistics ports when SOBEL_CTRL_STATS_EN is defined.
module tb_sobel_frame_ctrl;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        reset, start, pix_valid, pix_ready, window_valid, busy, frame_done;
  logic [7:0]  pix_in;
  logic [71:0] pixel_window;
  logic [11:0] win_row, win_col;

  logic        start3, pix_valid3, pix_ready3, window_valid3, busy3, frame_done3;
  logic [7:0]  pix_in3;
  logic [71:0] pixel_window3;
  logic [11:0] win_row3, win_col3;

`ifdef SOBEL_CTRL_STATS_EN
  logic [15:0] frames_done, frames_done3;
  logic        overrun, overrun3;
`endif

  typedef struct packed {
    logic [11:0] row;
    logic [11:0] col;
    logic [71:0] win;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          win_cnt  = 0;
  int          win3_cnt = 0;
  int          frames_exp = 0;
  bit          overrun_exp = 1'b0;
  logic [71:0] first_win;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pixel_window (pixel_window),
    .window_valid (window_valid),
    .win_row      (win_row),
    .win_col      (win_col),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef SOBEL_CTRL_STATS_EN
    ,
    .frames_done  (frames_done),
    .overrun      (overrun)
`endif
  );

  sobel_frame_ctrl #(
    .IMG_WIDTH  (3),
    .IMG_HEIGHT (3)
  ) dut3 (
    .clk          (clk),
    .reset        (reset),
    .start        (start3),
    .pix_in       (pix_in3),
    .pix_valid    (pix_valid3),
    .pix_ready    (pix_ready3),
    .pixel_window (pixel_window3),
    .window_valid (window_valid3),
    .win_row      (win_row3),
    .win_col      (win_col3),
    .busy         (busy3),
    .frame_done   (frame_done3)
`ifdef SOBEL_CTRL_STATS_EN
    ,
    .frames_done  (frames_done3),
    .overrun      (overrun3)
`endif
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ramp frame: pixel(r,c) = r*w + c; window centred on (r-1,c-1).
  function automatic logic [71:0] ramp_win(input int r, input int c, input int w);
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = 8'((r - 2 + k / 3) * w + (c - 2 + k % 3));
    return v;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (window_valid) begin
      win_cnt++;
      if (win_cnt == 1) first_win = pixel_window;
      if (sb_q.size() == 0) begin
        chk("unexpected_window", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("win_row", win_row, e.row);
        chk("win_col", win_col, e.col);
        chk("pixel_window", pixel_window, e.win);
      end
    end
  end

  always @(negedge clk) begin : mon3
    if (window_valid3) begin
      win3_cnt++;
      chk("w3_row", win_row3, 1);
      chk("w3_col", win_col3, 1);
      chk("w3_window", pixel_window3, ramp_win(2, 2, 3));
    end
  end

  task automatic run_frame(input bit gaps, input int start_at, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int r, c;
    bit v;
    exp_t e;
    win_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < W * H && cyc < 2000) begin
      if (idx == abort_at) begin
        pix_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", pix_ready, 0);
        chk("abort_wvalid", window_valid, 0);
        chk("abort_window", pixel_window, 0);
        chk("abort_row", win_row, 0);
        chk("abort_col", win_col, 0);
        chk("abort_done", frame_done, 0);
        sb_q.delete();
        frames_exp  = 0;
        overrun_exp = 1'b0;
        return;
      end
      v         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_valid = v;
      pix_in    = 8'(idx);
      start     = (idx == start_at);
      if (v && pix_ready) begin
        r = idx / W;
        c = idx % W;
        if (r >= 2 && c >= 2) begin
          e.row = 12'(r - 1);
          e.col = 12'(c - 1);
          e.win = ramp_win(r, c, W);
          sb_q.push_back(e);
        end
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    if (cyc >= 2000) chk("frame_timeout", 0, 1);
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_in_done", busy, 1);
    chk("ready_in_done", pix_ready, 0);
    chk("window_hold", pixel_window, ramp_win(H - 1, W - 1, W));
    @(negedge clk);
    chk("frame_done_clear", frame_done, 0);
    chk("busy_idle", busy, 0);
    chk("window_count", win_cnt, (W - 2) * (H - 2));
    chk("sb_empty", sb_q.size(), 0);
    frames_exp++;
  endtask

  initial begin
    logic [71:0] exp_first;
    reset      = 1'b1;
    start      = 1'b0;
    pix_valid  = 1'b0;
    pix_in     = '0;
    start3     = 1'b0;
    pix_valid3 = 1'b0;
    pix_in3    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wvalid", window_valid, 0);
    chk("rst_window", pixel_window, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_row", win_row, 0);
    reset = 1'b0;

    run_frame(1'b0, -1, -1);
    exp_first = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
    chk("first_window", first_win, exp_first);
    run_frame(1'b1, -1, -1);
    run_frame(1'b0, 30, -1);
    run_frame(1'b0, -1, 20);
    run_frame(1'b1, -1, -1);

    // Valid data while idle counts as an overrun.
    @(negedge clk);
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid   = 1'b0;
    overrun_exp = 1'b1;
    run_frame(1'b0, -1, -1);
    run_frame(1'b1, -1, -1);
`ifdef SOBEL_CTRL_STATS_EN
    chk("frames_done", frames_done, frames_exp);
    chk("overrun", overrun, overrun_exp);
`endif

    win3_cnt = 0;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("w3_ready", pix_ready3, 1);
      pix_valid3 = 1'b1;
      pix_in3    = 8'(i);
      @(negedge clk);
    end
    pix_valid3 = 1'b0;
    chk("w3_frame_done", frame_done3, 1);
    @(negedge clk);
    chk("w3_count", win3_cnt, 1);
    chk("w3_idle", busy3, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
